// File: rtl/my_microsequencer_if.sv
// Sequencer-side bundle between MICRO_ROM/My_State_ROM control and the micro-PC logic.
// master drives micro-word controls and observes status; slave is the sequencer.
interface my_microsequencer_if #(
  parameter int unsigned ADDR_W = 8
) ();
  logic [1:0]        i_addr_ctl;
  logic [ADDR_W-1:0] i_dispatch_state;
  logic              i_dispatch_valid;
  logic              i_stall;
  logic              i_cond_done;
  logic [ADDR_W-1:0] o_upc;
  logic              o_fetch;
  logic              o_illegal;
  logic              o_timeout;
  logic              o_halted;
  logic [15:0]       o_instr_count;

  modport master (
    output i_addr_ctl, i_dispatch_state, i_dispatch_valid, i_stall, i_cond_done,
    input  o_upc, o_fetch, o_illegal, o_timeout, o_halted, o_instr_count
  );

  modport slave (
    input  i_addr_ctl, i_dispatch_state, i_dispatch_valid, i_stall, i_cond_done,
    output o_upc, o_fetch, o_illegal, o_timeout, o_halted, o_instr_count
  );
endinterface

// File: rtl/my_microsequencer.sv
// Micro-PC sequencer: SEQ/FETCH/DISPATCH/WAIT next-address selection with bounded wait,
// global stall, instruction counting and a sticky trap (HALT) on illegal opcode or timeout.
module my_microsequencer #(
  parameter int unsigned       ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] FETCH_ADDR = '0,
  parameter logic [ADDR_W-1:0] TRAP_ADDR  = '1,
  parameter int unsigned       WAIT_MAX   = 40
) (
  input logic                i_clk,
  input logic                i_reset,
  my_microsequencer_if.slave sif
);
  localparam int unsigned WcntW = $clog2(WAIT_MAX + 1);
  localparam logic [WcntW-1:0] WcntLast = WcntW'(WAIT_MAX - 1);

  typedef enum logic {StRun, StHalt} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] upc_q, upc_d;
  logic [WcntW-1:0]  wcnt_q, wcnt_d;
  logic              fetch_q, fetch_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;
  logic [15:0]       count_q, count_d;

  always_comb begin
    state_d   = state_q;
    upc_d     = upc_q;
    wcnt_d    = wcnt_q;
    fetch_d   = 1'b0;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    count_d   = count_q;
    if (state_q == StRun && !sif.i_stall) begin
      unique case (sif.i_addr_ctl)
        2'b00: begin
          upc_d  = upc_q + ADDR_W'(1);
          wcnt_d = '0;
        end
        2'b01: begin
          upc_d   = FETCH_ADDR;
          count_d = count_q + 16'd1;
          fetch_d = 1'b1;
          wcnt_d  = '0;
        end
        2'b10: begin
          wcnt_d = '0;
          if (sif.i_dispatch_valid) begin
            upc_d = sif.i_dispatch_state;
          end else begin
            upc_d     = TRAP_ADDR;
            illegal_d = 1'b1;
            state_d   = StHalt;
          end
        end
        2'b11: begin
          // Completion on the final allowed cycle still beats the timeout.
          if (sif.i_cond_done) begin
            upc_d  = upc_q + ADDR_W'(1);
            wcnt_d = '0;
          end else if (wcnt_q == WcntLast) begin
            upc_d     = TRAP_ADDR;
            timeout_d = 1'b1;
            state_d   = StHalt;
          end else begin
            wcnt_d = wcnt_q + WcntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= StRun;
      upc_q     <= FETCH_ADDR;
      wcnt_q    <= '0;
      fetch_q   <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      upc_q     <= upc_d;
      wcnt_q    <= wcnt_d;
      fetch_q   <= fetch_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

  assign sif.o_upc         = upc_q;
  assign sif.o_fetch       = fetch_q;
  assign sif.o_illegal     = illegal_q;
  assign sif.o_timeout     = timeout_q;
  assign sif.o_halted      = (state_q == StHalt);
  assign sif.o_instr_count = count_q;
endmodule

// File: tb/tb_my_microsequencer.sv
// Bench for my_microsequencer: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the sequencing rules.
module tb_my_microsequencer;
  localparam int WaitMax = 40;
  localparam int Fetch   = 8'h00;
  localparam int Trap    = 8'hFF;

  logic i_clk = 1'b0;
  logic i_reset;
  int   n_total = 0;
  int   n_bad   = 0;

  // Reference model state
  int m_upc, m_count, m_waited;
  bit m_fetch, m_illegal, m_timeout, m_halted;

  my_microsequencer_if #(.ADDR_W(8)) sif ();

  my_microsequencer #(
    .ADDR_W    (8),
    .FETCH_ADDR(8'h00),
    .TRAP_ADDR (8'hFF),
    .WAIT_MAX  (WaitMax)
  ) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .sif    (sif.slave)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_halt();
    m_upc    = Trap;
    m_halted = 1'b1;
  endtask

  task automatic model_step(input bit rst, input int ctl, input int ds, input bit dv,
                            input bit stall, input bit done);
    m_fetch = 1'b0;
    if (rst) begin
      m_upc = Fetch; m_count = 0; m_waited = 0;
      m_illegal = 1'b0; m_timeout = 1'b0; m_halted = 1'b0;
    end else if (m_halted || stall) begin
      // frozen
    end else if (ctl == 0) begin
      m_upc = (m_upc + 1) % 256; m_waited = 0;
    end else if (ctl == 1) begin
      m_upc = Fetch; m_count = (m_count + 1) % 65536; m_fetch = 1'b1; m_waited = 0;
    end else if (ctl == 2) begin
      m_waited = 0;
      if (dv) m_upc = ds;
      else begin
        m_illegal = 1'b1; model_halt();
      end
    end else if (done) begin
      m_upc = (m_upc + 1) % 256; m_waited = 0;
    end else begin
      m_waited++;
      if (m_waited == WaitMax) begin
        m_timeout = 1'b1; model_halt();
      end
    end
  endtask

  // Drive one cycle, advance model, then compare all outputs 1 time unit after the edge.
  task automatic step(input bit rst, input int ctl, input int ds, input bit dv,
                      input bit stall, input bit done);
    i_reset              = rst;
    sif.i_addr_ctl       = 2'(ctl);
    sif.i_dispatch_state = 8'(ds);
    sif.i_dispatch_valid = dv;
    sif.i_stall          = stall;
    sif.i_cond_done      = done;
    @(posedge i_clk);
    model_step(rst, ctl, ds, dv, stall, done);
    #1;
    check_eq("upc", 32'(sif.o_upc), 32'(m_upc));
    check_eq("fetch", 32'(sif.o_fetch), 32'(m_fetch));
    check_eq("illegal", 32'(sif.o_illegal), 32'(m_illegal));
    check_eq("timeout", 32'(sif.o_timeout), 32'(m_timeout));
    check_eq("halted", 32'(sif.o_halted), 32'(m_halted));
    check_eq("count", 32'(sif.o_instr_count), 32'(m_count));
  endtask

  task automatic seq();      step(0, 0, 0, 1, 0, 0); endtask
  task automatic do_reset(); step(1, 0, 0, 1, 0, 0); endtask

  initial begin
    m_upc = 0; m_count = 0; m_waited = 0;
    m_fetch = 0; m_illegal = 0; m_timeout = 0; m_halted = 0;

    // Reset and SEQ
    do_reset();
    check_eq("rst_upc", 32'(sif.o_upc), 32'h00);
    for (int i = 1; i <= 3; i++) begin
      seq();
      check_eq("seq_upc", 32'(sif.o_upc), 32'(i));
    end

    // FETCH at 0x05 then DISPATCH to 0x10
    seq(); seq();
    check_eq("at5", 32'(sif.o_upc), 32'h05);
    step(0, 1, 0, 1, 0, 0);
    check_eq("fetch_upc", 32'(sif.o_upc), 32'h00);
    check_eq("fetch_pulse", 32'(sif.o_fetch), 32'd1);
    check_eq("fetch_cnt", 32'(sif.o_instr_count), 32'd1);
    step(0, 2, 8'h10, 1, 0, 0);
    check_eq("disp_upc", 32'(sif.o_upc), 32'h10);
    check_eq("disp_nofetch", 32'(sif.o_fetch), 32'd0);

    // Illegal dispatch, then ignored traffic, then reset
    step(0, 2, 8'h20, 0, 0, 0);
    check_eq("ill_upc", 32'(sif.o_upc), 32'hFF);
    check_eq("ill_flag", 32'(sif.o_illegal), 32'd1);
    check_eq("ill_halt", 32'(sif.o_halted), 32'd1);
    seq(); step(0, 1, 0, 1, 1, 0); step(0, 1, 0, 1, 0, 0);
    check_eq("halt_hold", 32'(sif.o_upc), 32'hFF);
    do_reset();
    check_eq("rst_clr", 32'({sif.o_upc, sif.o_illegal, sif.o_halted}), 32'h0);

    // WAIT with stalls: 0x10 held for 7 cycles, then 0x11
    step(0, 2, 8'h10, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 3, 0, 1, (i == 1 || i == 4), 0);
      check_eq("wait_hold", 32'(sif.o_upc), 32'h10);
    end
    step(0, 3, 0, 1, 0, 1);
    check_eq("wait_done", 32'(sif.o_upc), 32'h11);
    check_eq("wait_noto", 32'(sif.o_timeout), 32'd0);

    // Timeout after exactly WaitMax cycles
    step(0, 2, 8'h10, 1, 0, 0);
    for (int i = 0; i < WaitMax - 1; i++) step(0, 3, 0, 1, 0, 0);
    check_eq("to_pre", 32'({sif.o_upc, sif.o_halted}), 32'h20);
    step(0, 3, 0, 1, 0, 0);
    check_eq("to_upc", 32'(sif.o_upc), 32'hFF);
    check_eq("to_flag", 32'(sif.o_timeout), 32'd1);
    do_reset();

    // Done on the final cycle wins
    step(0, 2, 8'h10, 1, 0, 0);
    for (int i = 0; i < WaitMax - 1; i++) step(0, 3, 0, 1, 0, 0);
    step(0, 3, 0, 1, 0, 1);
    check_eq("last_done_upc", 32'(sif.o_upc), 32'h11);
    check_eq("last_done_to", 32'(sif.o_timeout), 32'd0);

    // Reset beats a simultaneous illegal dispatch
    step(1, 2, 0, 0, 0, 0);
    check_eq("rst_wins", 32'({sif.o_illegal, sif.o_halted}), 32'd0);

    // SEQ wrap does not pulse fetch
    step(0, 2, 8'hFE, 1, 0, 0);
    seq();
    check_eq("wrap_ff", 32'(sif.o_upc), 32'hFF);
    seq();
    check_eq("wrap_00", 32'({sif.o_upc, sif.o_fetch}), 32'd0);
    check_eq("wrap_cnt", 32'(sif.o_instr_count), 32'd0);

    // Randomized segments, some biased toward long WAITs
    for (int seg = 0; seg < 40; seg++) begin
      bit wbias = (seg % 3 == 0);
      for (int c = 0; c < 100; c++) begin
        bit rst   = m_halted ? ($urandom_range(3) == 0) : ($urandom_range(199) == 0);
        int ctl   = wbias ? (($urandom_range(7) == 0) ? int'($urandom_range(3)) : 3)
                          : int'($urandom_range(3));
        bit dv    = ($urandom_range(15) != 0);
        bit stall = ($urandom_range(3) == 0);
        bit done  = wbias ? ($urandom_range(63) == 0) : ($urandom_range(3) == 0);
        step(rst, ctl, int'($urandom_range(255)), dv, stall, done);
      end
    end

    // Instruction counter wrap
    do_reset();
    for (int i = 0; i < 65535; i++) step(0, 1, 0, 1, 0, 0);
    check_eq("cnt_max", 32'(sif.o_instr_count), 32'hFFFF);
    step(0, 1, 0, 1, 0, 0);
    check_eq("cnt_wrap", 32'(sif.o_instr_count), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
